// File: rtl/hpu_mem_arb.sv
// Round-robin arbiter sharing the hpu_mem request port among NREQ requesters.
// Tracks each issue through S1 (suc, issue+1) and S2 (rdata, issue+2) and
// re-issues failed attempts ahead of new traffic until RETRY_MAX is exhausted.
module hpu_mem_arb #(
  parameter int NREQ      = 3,
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int RETRY_MAX = 15
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NREQ-1:0]      req_vld_i,
  input  logic [NREQ-1:0]      req_we_i,
  input  logic [NREQ*AW-1:0]   req_addr_i,
  input  logic [NREQ*DW-1:0]   req_wdata_i,
  input  logic [NREQ*DW/8-1:0] req_wstrb_i,
  output logic [NREQ-1:0]      req_done_o,
  output logic                 req_err_o,
  output logic [DW-1:0]        rsp_rdata_o,
  output logic                 mem_wr_en_o,
  output logic                 mem_rd_en_o,
  output logic [AW-1:0]        mem_addr_o,
  output logic [DW-1:0]        mem_wdata_o,
  output logic [DW/8-1:0]      mem_wstrb_o,
  input  logic                 mem_wr_suc_i,
  input  logic                 mem_rd_suc_i,
  input  logic [DW-1:0]        mem_rdata_i
);

  localparam int SW = DW / 8;
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = 8;

  typedef logic [PW-1:0] idx_t;
  typedef logic [CW-1:0] cnt_t;

  // Pipeline and arbitration state
  logic     s1_vld;
  idx_t     s1_owner;
  logic     s1_we;
  cnt_t     s1_cnt;
  logic     s2_vld;
  idx_t     s2_owner;
  idx_t     rr_ptr;
  logic     retry_vld;
  idx_t     retry_owner;
  cnt_t     retry_cnt;

  // Combinational arbitration results
  logic [NREQ-1:0] busy;
  logic [NREQ-1:0] elig;
  logic            gnt_vld;
  logic            gnt_retry;
  idx_t            gnt_idx;
  logic            gnt_we;
  logic [AW-1:0]   gnt_addr;
  logic [DW-1:0]   gnt_wdata;
  logic [SW-1:0]   gnt_wstrb;
  idx_t            rr_next;

  // S1 evaluation
  logic s1_suc;
  logic s1_fail;
  logic s1_exh;
  logic s1_retry;
  logic s1_wr_done;
  logic s1_rd_ok;

  // Requesters with an attempt in S1 or a read in S2 cannot be granted again
  always_comb begin
    busy = '0;
    if (s1_vld) busy[s1_owner] = 1'b1;
    if (s2_vld) busy[s2_owner] = 1'b1;
    elig = req_vld_i & ~busy;
  end

  // Grant: pending retry owner first, otherwise first eligible at/after rr_ptr
  always_comb begin
    int unsigned idx;
    idx       = 0;
    gnt_vld   = 1'b0;
    gnt_retry = 1'b0;
    gnt_idx   = '0;
    if (retry_vld && elig[retry_owner]) begin
      gnt_vld   = 1'b1;
      gnt_retry = 1'b1;
      gnt_idx   = retry_owner;
    end else begin
      for (int unsigned k = 0; k < NREQ; k++) begin
        idx = (32'(rr_ptr) + k) % 32'(NREQ);
        if (!gnt_vld && elig[idx_t'(idx)]) begin
          gnt_vld = 1'b1;
          gnt_idx = idx_t'(idx);
        end
      end
    end
    rr_next = (gnt_idx == idx_t'(NREQ - 1)) ? '0 : gnt_idx + idx_t'(1);
  end

  // Payload mux from the granted requester slice
  always_comb begin
    gnt_we    = 1'b0;
    gnt_addr  = '0;
    gnt_wdata = '0;
    gnt_wstrb = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt_vld && gnt_idx == idx_t'(i)) begin
        gnt_we    = req_we_i[i];
        gnt_addr  = req_addr_i[i*AW +: AW];
        gnt_wdata = req_wdata_i[i*DW +: DW];
        gnt_wstrb = req_wstrb_i[i*SW +: SW];
      end
    end
  end

  // S1 outcome: success, retryable failure, or exhausted failure
  always_comb begin
    s1_suc     = s1_we ? mem_wr_suc_i : mem_rd_suc_i;
    s1_fail    = s1_vld & ~s1_suc;
    s1_exh     = s1_fail && (s1_cnt == cnt_t'(RETRY_MAX));
    s1_retry   = s1_fail && !s1_exh;
    s1_wr_done = s1_vld & s1_we & s1_suc;
    s1_rd_ok   = s1_vld & ~s1_we & s1_suc;
  end

  // Outputs; everything is held at 0 while reset is asserted
  always_comb begin
    req_done_o  = '0;
    req_err_o   = 1'b0;
    rsp_rdata_o = '0;
    mem_wr_en_o = 1'b0;
    mem_rd_en_o = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_wstrb_o = '0;
    if (!rst_i) begin
      if (s1_wr_done || s1_exh) req_done_o[s1_owner] = 1'b1;
      if (s2_vld) begin
        req_done_o[s2_owner] = 1'b1;
        rsp_rdata_o          = mem_rdata_i;
      end
      req_err_o   = s1_exh;
      mem_wr_en_o = gnt_vld & gnt_we;
      mem_rd_en_o = gnt_vld & ~gnt_we;
      mem_addr_o  = gnt_addr;
      mem_wdata_o = gnt_wdata;
      mem_wstrb_o = gnt_wstrb;
    end
  end

  // Pipeline stages, round-robin pointer and retry bookkeeping
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_vld      <= 1'b0;
      s1_owner    <= '0;
      s1_we       <= 1'b0;
      s1_cnt      <= '0;
      s2_vld      <= 1'b0;
      s2_owner    <= '0;
      rr_ptr      <= '0;
      retry_vld   <= 1'b0;
      retry_owner <= '0;
      retry_cnt   <= '0;
    end else begin
      s1_vld   <= gnt_vld;
      s1_owner <= gnt_idx;
      s1_we    <= gnt_we;
      s1_cnt   <= gnt_retry ? retry_cnt : '0;
      s2_vld   <= s1_rd_ok;
      s2_owner <= s1_owner;
      if (gnt_vld && !gnt_retry) rr_ptr <= rr_next;
      // A new failure can only come from a different owner than a pending
      // retry being granted this cycle, so setting wins over clearing.
      if (s1_retry) begin
        retry_vld   <= 1'b1;
        retry_owner <= s1_owner;
        retry_cnt   <= s1_cnt + cnt_t'(1);
      end else if (gnt_retry || (retry_vld && !req_vld_i[retry_owner])) begin
        retry_vld <= 1'b0;
        retry_cnt <= '0;
      end
    end
  end

endmodule
